fetch_stage: RTL

- Instruction fetch stage: owns the PC, issues word reads to a synchronous instruction memory, and buffers the returned instructions.
- Presents {pc, insn} pairs to the downstream decode stage over a valid/ready handshake.
- Accepts PC redirects from execute/branch resolution; a redirect discards all wrong-path fetches.
- First pipeline stage of the five-stage core.

---
 rtl/fetch_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and buffers returned {pc, insn} pairs for decode.
// Latency: imem_req in cycle N gives out_valid in cycle N+2. Redirects cost
// 2 bubble cycles on the request side and at least 4 cycles to new output.
// Backpressure: out_ready=0 holds the head stable; requests stop once
// buffered + in-flight entries would reach BUF_DEPTH, so nothing is dropped.
//
// Ports:
//   clock, reset              sole clock; synchronous active-low reset
//   imem_req/imem_addr        word read request to instruction memory
//   imem_rdata                read data, valid the cycle after imem_req
//   redirect_valid/_pc        PC redirect from branch resolution
//   out_valid/out_ready       valid/ready handshake towards decode
//   out_pc/out_insn           head entry (zero while out_valid=0)
//   stat_fetched/stat_stall   only with FETCH_STATS_EN defined: accepted
//                             instructions and stalled-head cycles
//
// Optional feature macro: FETCH_STATS_EN

module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0100_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_insn
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall
`endif
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    issued_pc_q, issued_pc_d;
    logic           inflight_q, inflight_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    entry_t         ibuf_q [BUF_DEPTH];

    logic           deq;
    logic           redir;
    logic           cap;
    logic           issue;
    logic [CW:0]    occ;
    entry_t         head;

    // The low address bits of a redirect target are forced to zero.
    logic           redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Head of the buffer; outputs read zero when nothing is buffered so the
    // uninitialised storage never leaks out.
    assign head      = ibuf_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? head.pc   : 32'h0;
    assign out_insn  = out_valid ? head.insn : 32'h0;

    assign deq = out_valid & out_ready;

    // A redirect is ignored in RST; the reset state owns the PC there.
    assign redir = redirect_valid && (state_q != ST_RST);

    // A response arriving in a redirect cycle is wrong-path and is dropped
    // together with the rest of the buffer.
    assign cap = inflight_q && !redir;

    // Entries that will occupy the buffer once the outstanding read lands,
    // counting a head leaving this cycle as already gone.
    assign occ   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(deq);
    assign issue = (state_q == ST_RUN) && !redir && (occ < {1'b0, DEPTH_C});

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    // Next-state, PC and buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        unique case (state_q)
            ST_RST:   state_d = ST_RUN;
            ST_RUN:   state_d = redir ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = redir ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_RST;
        endcase

        if (redir) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            pc_d        = pc_q + 32'd4;
            issued_pc_d = pc_q;
            inflight_d  = 1'b1;
        end

        if (redir) begin
            // The head handshake of this cycle (if any) still completes;
            // everything else, including this cycle's response, is discarded.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (cap) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(cap) - CW'(deq);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_RST;
            pc_q        <= PC_RESET;
            issued_pc_q <= 32'h0;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Buffer storage has no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (reset && cap) begin
            ibuf_q[wr_ptr_q] <= '{pc: issued_pc_q, insn: imem_rdata};
        end
    end

    // The issue rule guarantees a free slot for every returning response.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(cap && (count_q == DEPTH_C)));
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_fetched_q <= 32'h0;
            stat_stall_q   <= 32'h0;
        end else begin
            if (deq) begin
                stat_fetched_q <= stat_fetched_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule
